pwm_demod: RTL
==============

// Module: pwm_demod
// PURPOSE
//  Receive-side counterpart of the PWM byte transmitter: decodes a serial PWM line back into bytes.
//  Each bit is one period of 10*base clocks and starts with a rising edge; data is sent LSB first.
//  A long high pulse (~8*base) is a 1; a short high pulse (~2*base) is a 0.
//  Every 8 decoded bits are written as one byte into the downstream RX FIFO.
// PARAMETERS
//  BITS_PER_DC   22     width of base_counter; all internal counters are BITS_PER_DC+5 bits
//  BASE_DEFAULT  21978  reset value of the active base count (must match transmitter default)
//  MIN_PULSE     4      high pulses shorter than this many clocks are glitches and are ignored
// PORTS
//  clk              in   1            single clock domain
//  reset            in   1            asynchronous, active-high; clears all state
//  pwm_in           in   1            PWM line, asynchronous to clk
//  base_cnt_update  in   1            one-cycle strobe: capture base_counter
//  base_counter     in   BITS_PER_DC  new base count (clocks per 1/10 bit period)
//  fifo_dout        out  8            decoded byte to RX FIFO
//  fifo_WE          out  1            one-cycle write strobe for fifo_dout
//  fifo_full        in   1            RX FIFO full
//  rx_busy          out  1            high while state != IDLE
//  frame_err        out  1            one-cycle pulse: partial byte discarded, or stuck-high line
//  overflow         out  1            one-cycle pulse: byte dropped because fifo_full was high
// BEHAVIOUR
//  Reset values: all outputs 0, state=IDLE, bit_cnt=0, shift=0, base_act=base_pend=BASE_DEFAULT.
//  Input path: 2-flop synchroniser, then registered edge detect (rise/fall pulses).
//   Edge pulses lag pwm_in by 3 clocks.
//  Thresholds are computed from base_act, zero-extended to BITS_PER_DC+5 bits:
//   t_half = 5*base (b<<2 + b); t_per = 10*base (b<<3 + b<<1); t_idle = 2*t_per.
//  base_cnt_update loads base_pend on any cycle.
//   base_pend is copied to base_act only while in IDLE, so a bit in flight never changes threshold.
//  hi_cnt and lo_cnt saturate at all-ones and never wrap.
//  FSM:
//   IDLE: on rise -> HIGH, hi_cnt=1.
//   HIGH: each cycle hi_cnt++.
//    On fall with hi_cnt<MIN_PULSE: glitch, no bit; return to IDLE if bit_cnt==0, else to LOW
//     (lo_cnt keeps counting).
//    On fall otherwise: bit = (hi_cnt >= t_half); shift = {bit, shift[7:1]}; bit_cnt++;
//     lo_cnt=1; -> LOW.
//    If hi_cnt reaches t_per: frame_err pulse, discard partial byte, bit_cnt=0 -> STUCK.
//   LOW: each cycle lo_cnt++.
//    On rise: -> HIGH, hi_cnt=1.
//    If lo_cnt reaches t_idle: -> IDLE; frame_err pulse iff bit_cnt!=0; bit_cnt=0.
//   STUCK: wait for fall -> IDLE. No bits are decoded in STUCK.
//  Byte completion: when bit_cnt goes 7->0 on the 8th fall, on the next clock:
//   if !fifo_full: fifo_dout=byte, fifo_WE=1 for exactly 1 cycle;
//   else: overflow=1 for 1 cycle, byte dropped, fifo_WE stays 0.
//   fifo_dout holds its last written value between writes.
//  Simultaneous events:
//   rise and idle-timeout on the same cycle: the rise wins (-> HIGH, no frame_err).
//   fall and stuck-timeout on the same cycle: the fall wins (bit decoded).
//  Latency: pwm_in falling edge of bit 7 -> fifo_WE is 4 clocks.
//  Back-to-back bytes need no gap; the next bit's rise can arrive on the same cycle as fifo_WE.
//  Reset mid-byte: partial data is lost silently (no frame_err), FSM returns to IDLE.
// STRUCTURE
//  pwm_pkg: BITS_PER_DC, BASE_DEFAULT, state encoding (IDLE/HIGH/LOW/STUCK),
//   threshold functions t_half/t_per/t_idle. The transmitter also uses this package.
//  Sub-module pwm_edge_sync: 2-flop synchroniser plus registered rise/fall detector.
//  The FSM, counters, shift register and FIFO write logic are in this module.
// TESTING (base_counter=10 loaded in IDLE => t_per=100, t_half=50, t_idle=200)
//  1 Send byte 8'hA5 with encoder timing (1: 79 high/21 low; 0: 19 high/81 low)
//    -> one fifo_WE, fifo_dout=8'hA5, frame_err=0.
//  2 Send 8'h00 then 8'hFF back-to-back -> two fifo_WE pulses, data 00 then FF.
//  3 Send 3 bits, then hold the line low for 250 clocks -> frame_err pulse ~200 clocks after
//    the last fall; the next full byte 8'h3C decodes correctly.
//  4 Insert 2-clock high glitches inside low phases -> decoded byte unchanged.
//  5 Hold fifo_full=1 and send 8'h5A -> overflow pulse, no fifo_WE.
//    Release fifo_full and send 8'h5A again -> normal write.
//  6 Hold pwm_in high for 120 clocks -> frame_err, then STUCK; after the fall, FSM is IDLE.
//    Strobe base update mid-byte -> current byte still decodes with the old base.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared PWM link definitions: default timing constants, decoder state encoding
// and the bit-period threshold helpers used by both ends of the link.
package pwm_pkg;

    localparam int unsigned BITS_PER_DC  = 22;
    localparam int unsigned BASE_DEFAULT = 21978;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HIGH  = 2'd1,
        LOW   = 2'd2,
        STUCK = 2'd3
    } pwm_state_e;

    // Helpers work on a wide value; callers truncate to their own counter width.
    function automatic logic [63:0] t_half(input logic [63:0] base);
        return (base << 2) + base;
    endfunction

    function automatic logic [63:0] t_per(input logic [63:0] base);
        return (base << 3) + (base << 1);
    endfunction

    function automatic logic [63:0] t_idle(input logic [63:0] base);
        return t_per(base) << 1;
    endfunction

endpackage

// File: rtl/pwm_edge_sync.sv
// Brings the asynchronous PWM line into the clock domain and produces
// single-cycle registered rise/fall pulses, three clocks behind the line.
module pwm_edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic pwm_i,
    output logic rise_o,
    output logic fall_o
);

    logic sync1_q, sync2_q, prev_q, rise_q, fall_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= pwm_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            rise_q  <= sync2_q & ~prev_q;
            fall_q  <= prev_q & ~sync2_q;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/pwm_demod.sv
// PWM line decoder: measures high/low pulse widths against thresholds derived
// from the base count and assembles LSB-first bytes into the RX FIFO.
module pwm_demod #(
    parameter int unsigned BITS_PER_DC  = pwm_pkg::BITS_PER_DC,
    parameter int unsigned BASE_DEFAULT = pwm_pkg::BASE_DEFAULT,
    parameter int unsigned MIN_PULSE    = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   pwm_in,
    input  logic                   base_cnt_update,
    input  logic [BITS_PER_DC-1:0] base_counter,
    output logic [7:0]             fifo_dout,
    output logic                   fifo_WE,
    input  logic                   fifo_full,
    output logic                   rx_busy,
    output logic                   frame_err,
    output logic                   overflow
);

    import pwm_pkg::*;

    localparam int unsigned CW = BITS_PER_DC + 5;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    logic rise, fall;

    pwm_edge_sync u_edge_sync (
        .clk    (clk),
        .reset  (reset),
        .pwm_i  (pwm_in),
        .rise_o (rise),
        .fall_o (fall)
    );

    pwm_state_e             state_q, state_d;
    logic [BITS_PER_DC-1:0] base_act_q, base_act_d;
    logic [BITS_PER_DC-1:0] base_pend_q, base_pend_d;
    logic [CW-1:0]          hi_cnt_q, hi_cnt_d;
    logic [CW-1:0]          lo_cnt_q, lo_cnt_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             shift_q, shift_d;
    logic [7:0]             dout_q, dout_d;
    logic                   we_q, we_d;
    logic                   frame_err_q, frame_err_d;
    logic                   overflow_q, overflow_d;

    logic [CW-1:0] th_half, th_per, th_idle;
    logic [7:0]    shift_next;
    logic          bit_val;

    assign th_half = CW'(t_half(64'(base_act_q)));
    assign th_per  = CW'(t_per(64'(base_act_q)));
    assign th_idle = CW'(t_idle(64'(base_act_q)));

    assign bit_val    = (hi_cnt_q >= th_half);
    assign shift_next = {bit_val, shift_q[7:1]};

    always_comb begin
        state_d     = state_q;
        hi_cnt_d    = hi_cnt_q;
        lo_cnt_d    = lo_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        dout_d      = dout_q;
        we_d        = 1'b0;
        frame_err_d = 1'b0;
        overflow_d  = 1'b0;
        base_pend_d = base_cnt_update ? base_counter : base_pend_q;
        // Thresholds only move between frames, never under a bit in flight.
        base_act_d  = (state_q == IDLE) ? base_pend_q : base_act_q;

        unique case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d  = HIGH;
                    hi_cnt_d = CW'(1);
                end
            end
            HIGH: begin
                hi_cnt_d = sat_inc(hi_cnt_q);
                lo_cnt_d = sat_inc(lo_cnt_q);
                if (fall) begin
                    if (hi_cnt_q < CW'(MIN_PULSE)) begin
                        state_d = (bit_cnt_q == '0) ? IDLE : LOW;
                    end else begin
                        shift_d   = shift_next;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        lo_cnt_d  = CW'(1);
                        state_d   = LOW;
                        if (bit_cnt_q == 3'd7) begin
                            if (fifo_full) begin
                                overflow_d = 1'b1;
                            end else begin
                                we_d   = 1'b1;
                                dout_d = shift_next;
                            end
                        end
                    end
                end else if (hi_cnt_q >= th_per) begin
                    frame_err_d = 1'b1;
                    bit_cnt_d   = '0;
                    shift_d     = '0;
                    state_d     = STUCK;
                end
            end
            LOW: begin
                lo_cnt_d = sat_inc(lo_cnt_q);
                if (rise) begin
                    state_d  = HIGH;
                    hi_cnt_d = CW'(1);
                end else if (lo_cnt_q >= th_idle) begin
                    frame_err_d = (bit_cnt_q != '0);
                    bit_cnt_d   = '0;
                    shift_d     = '0;
                    state_d     = IDLE;
                end
            end
            STUCK: begin
                if (fall) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            base_act_q  <= BITS_PER_DC'(BASE_DEFAULT);
            base_pend_q <= BITS_PER_DC'(BASE_DEFAULT);
            hi_cnt_q    <= '0;
            lo_cnt_q    <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            dout_q      <= '0;
            we_q        <= 1'b0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_act_q  <= base_act_d;
            base_pend_q <= base_pend_d;
            hi_cnt_q    <= hi_cnt_d;
            lo_cnt_q    <= lo_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            dout_q      <= dout_d;
            we_q        <= we_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
        end
    end

    assign fifo_dout = dout_q;
    assign fifo_WE   = we_q;
    assign rx_busy   = (state_q != IDLE);
    assign frame_err = frame_err_q;
    assign overflow  = overflow_q;

endmodule
